// File: rtl/mcs4_bus_phaser_if.sv
// rtl/mcs4_bus_phaser_if.sv - core/pad bus bundle for the MCS-4 bus phaser
interface mcs4_bus_phaser_if #(
   parameter int DATA_W  = 4,
   parameter int N_CMRAM = 4
);
   logic [DATA_W-1:0]  core_data_out;
   logic               core_data_oe;
   logic               core_cmrom;
   logic [N_CMRAM-1:0] core_cmram;
   logic [DATA_W-1:0]  bus_in;
   logic [DATA_W-1:0]  bus_out;
   logic               bus_oe;
   logic [DATA_W-1:0]  data_in_q;
   logic               cmrom;
   logic [N_CMRAM-1:0] cmram;

   // core and pads: drive requests and pad input, observe phased results
   modport master (
      output core_data_out, core_data_oe, core_cmrom, core_cmram, bus_in,
      input  bus_out, bus_oe, data_in_q, cmrom, cmram
   );

   // phaser: consume requests and pad input, drive pads and strobes
   modport slave (
      input  core_data_out, core_data_oe, core_cmrom, core_cmram, bus_in,
      output bus_out, bus_oe, data_in_q, cmrom, cmram
   );
endinterface

// File: rtl/mcs4_bus_phaser.sv
// rtl/mcs4_bus_phaser.sv - MCS-4 two-phase clock, subcycle, bus and POC engine
module mcs4_bus_phaser #(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 4,
   parameter int N_CMRAM = 4,
   parameter int POC_CYC = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                poc_in,
   mcs4_bus_phaser_if.slave    bus,
   output logic                clk1,
   output logic                clk2,
   output logic [7:0]          phase,
   output logic                sync,
   output logic                poc
);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int STR_LEN = POC_CYC * 8;
   localparam int STR_W   = $clog2(STR_LEN);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [STR_W-1:0] STR_LAST = STR_W'(STR_LEN - 1);

   typedef enum logic [2:0] {
      SUB_A1, SUB_A2, SUB_A3, SUB_M1, SUB_M2, SUB_X1, SUB_X2, SUB_X3
   } sub_t;

   logic [DIV_W-1:0]   div_q, div_d;
   logic [1:0]         tick_q, tick_d;
   sub_t               sub_q, sub_d;
   logic               enter_t0;
   logic               leave_t2;
   logic               strobe_sub;
   logic [STR_W-1:0]   str_q;
   logic [DATA_W-1:0]  out_q;
   logic               oe_q;
   logic [DATA_W-1:0]  din_q;
   logic               cmrom_q;
   logic [N_CMRAM-1:0] cmram_q;

   assign bus.bus_out   = out_q;
   assign bus.bus_oe    = oe_q;
   assign bus.data_in_q = din_q;
   assign bus.cmrom     = cmrom_q;
   assign bus.cmram     = cmram_q;

   // Next timebase position; poc_in pins the machine at A1/tick0/div0
   always_comb begin
      div_d    = div_q;
      tick_d   = tick_q;
      sub_d    = sub_q;
      enter_t0 = 1'b0;
      leave_t2 = 1'b0;
      if (poc_in) begin
         div_d  = '0;
         tick_d = 2'd0;
         sub_d  = SUB_A1;
      end else if (div_q == DIV_LAST) begin
         div_d    = '0;
         tick_d   = tick_q + 2'd1;
         leave_t2 = (tick_q == 2'd2);
         if (tick_q == 2'd3) begin
            enter_t0 = 1'b1;
            sub_d    = sub_t'(sub_q + 3'd1);
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
      strobe_sub = (sub_d == SUB_A3) || (sub_d == SUB_M2) || (sub_d == SUB_X2);
   end

   // Timebase state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         tick_q <= 2'd0;
         sub_q  <= SUB_A1;
      end else if (ena) begin
         div_q  <= div_d;
         tick_q <= tick_d;
         sub_q  <= sub_d;
      end
   end

   // Registered outputs: clocks, phase strobes, bus turnaround, CM gating, POC stretch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk1    <= 1'b0;
         clk2    <= 1'b0;
         phase   <= 8'h01;
         sync    <= 1'b0;
         out_q   <= '0;
         oe_q    <= 1'b0;
         din_q   <= '0;
         cmrom_q <= 1'b0;
         cmram_q <= '0;
         poc     <= 1'b1;
         str_q   <= '0;
      end else if (ena) begin
         clk1  <= (tick_d == 2'd0);
         clk2  <= (tick_d == 2'd2);
         phase <= 8'h01 << sub_d;
         sync  <= (sub_d == SUB_X3);
         if (poc_in) begin
            oe_q    <= 1'b0;
            cmrom_q <= 1'b0;
            cmram_q <= '0;
            poc     <= 1'b1;
            str_q   <= '0;
         end else begin
            if (enter_t0) begin
               oe_q    <= bus.core_data_oe;
               out_q   <= bus.core_data_out;
               cmrom_q <= bus.core_cmrom & strobe_sub;
               cmram_q <= strobe_sub ? bus.core_cmram : '0;
            end
            // tick3 is the turnaround slot, and clk2 falls here
            if (leave_t2) begin
               oe_q  <= 1'b0;
               din_q <= bus.bus_in;
            end
            if (poc && enter_t0) begin
               if (str_q == STR_LAST) begin
                  poc <= 1'b0;
               end else begin
                  str_q <= str_q + STR_W'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_mcs4_bus_phaser.sv
// tb/tb_mcs4_bus_phaser.sv - scoreboard bench for mcs4_bus_phaser
`timescale 1ns/1ps
module tb_mcs4_bus_phaser;
   localparam int CD      = 2;
   localparam int SUBC    = 4 * CD;
   localparam int POC_LEN = 8 * SUBC;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       poc_in = 1'b0;
   logic       clk1, clk2, sync, poc;
   logic [7:0] phase;

   mcs4_bus_phaser_if #(.DATA_W(4), .N_CMRAM(4)) bif ();

   mcs4_bus_phaser #(.CLK_DIV(CD), .DATA_W(4), .N_CMRAM(4), .POC_CYC(1)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .poc_in(poc_in), .bus(bif),
      .clk1(clk1), .clk2(clk2), .phase(phase), .sync(sync), .poc(poc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       clk1;
      logic       clk2;
      logic [7:0] phase;
      logic       sync;
      logic       bus_oe;
      logic [3:0] bus_out;
      logic [3:0] dq;
      logic       cmrom;
      logic [3:0] cmram;
      logic       poc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cnt;
   logic       cap_oe, cap_rom;
   logic [3:0] cap_out, cap_ram, cap_dq;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      cnt = 0; cap_oe = 0; cap_rom = 0; cap_out = 0; cap_ram = 0; cap_dq = 0;
   endtask

   task automatic check_reset(input string tag);
      check_val({tag, "_clk1"}, clk1, 0);
      check_val({tag, "_clk2"}, clk2, 0);
      check_val({tag, "_phase"}, phase, 8'h01);
      check_val({tag, "_sync"}, sync, 0);
      check_val({tag, "_bus_out"}, bif.bus_out, 0);
      check_val({tag, "_bus_oe"}, bif.bus_oe, 0);
      check_val({tag, "_dq"}, bif.data_in_q, 0);
      check_val({tag, "_cmrom"}, bif.cmrom, 0);
      check_val({tag, "_cmram"}, bif.cmram, 0);
      check_val({tag, "_poc"}, poc, 1);
   endtask

   task automatic step(input logic e, input logic p);
      exp_t x;
      int   tk, sb;
      logic strobe;
      @(negedge clk);
      ena = e;
      poc_in = p;
      bif.core_data_out = 4'($urandom);
      bif.core_data_oe  = 1'($urandom);
      bif.core_cmrom    = 1'($urandom);
      bif.core_cmram    = 4'($urandom);
      bif.bus_in        = 4'($urandom);
      if (e) begin
         if (p) begin
            cnt = 0; cap_oe = 0; cap_rom = 0; cap_ram = 0;
         end else begin
            cnt++;
            sb = (cnt / SUBC) % 8;
            strobe = (sb == 2) || (sb == 4) || (sb == 6);
            if (cnt % SUBC == 0) begin
               cap_oe  = bif.core_data_oe;
               cap_out = bif.core_data_out;
               cap_rom = bif.core_cmrom & strobe;
               cap_ram = strobe ? bif.core_cmram : 4'h0;
            end
            if (cnt % SUBC == 3 * CD) cap_dq = bif.bus_in;
         end
      end
      tk = (cnt / CD) % 4;
      sb = (cnt / SUBC) % 8;
      x.clk1    = (tk == 0);
      x.clk2    = (tk == 2);
      x.phase   = 8'h01 << sb;
      x.sync    = (sb == 7);
      x.bus_oe  = cap_oe && (tk != 3);
      x.bus_out = cap_out;
      x.dq      = cap_dq;
      x.cmrom   = cap_rom;
      x.cmram   = cap_ram;
      x.poc     = (cnt < POC_LEN);
      sb_q.push_back(x);
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check_val("clk1", clk1, x.clk1);
      check_val("clk2", clk2, x.clk2);
      check_val("no_overlap", clk1 & clk2, 0);
      check_val("phase", phase, x.phase);
      check_val("sync", sync, x.sync);
      check_val("bus_oe", bif.bus_oe, x.bus_oe);
      check_val("bus_out", bif.bus_out, x.bus_out);
      check_val("data_in_q", bif.data_in_q, x.dq);
      check_val("cmrom", bif.cmrom, x.cmrom);
      check_val("cmram", bif.cmram, x.cmram);
      check_val("poc", poc, x.poc);
   endtask

   initial begin
      logic [7:0] held_phase;
      bif.core_data_out = 0; bif.core_data_oe = 0; bif.core_cmrom = 0;
      bif.core_cmram = 0; bif.bus_in = 0;
      model_reset();
      #17;
      check_reset("rst");
      rst_n = 1'b1;

      // free run through two instruction cycles, POC expiry included
      for (int i = 0; i < 150; i++) step(1'b1, 1'b0);

      // land in X1 tick1, then pulse poc_in
      for (int i = 0; i < 64; i++) begin
         if (((cnt / SUBC) % 8) == 5 && ((cnt / CD) % 4) == 1) break;
         step(1'b1, 1'b0);
      end
      check_val("reach_x1", ((cnt / SUBC) % 8), 5);
      step(1'b1, 1'b1);
      check_val("poc_snap_phase", phase, 8'h01);
      check_val("poc_snap_clk1", clk1, 1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

      // three frozen clocks must not move anything
      held_phase = phase;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check_val("ena_hold_phase", phase, held_phase);
      for (int i = 0; i < 80; i++) step(1'b1, 1'b0);

      // mixed stalls and sporadic POC requests
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);

      // asynchronous reset mid-operation, away from any clock edge
      #2 rst_n = 1'b0;
      #1 check_reset("mid_rst");
      model_reset();
      #0.5 rst_n = 1'b1;
      for (int i = 0; i < 80; i++) step(1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
